// File: rtl/resp_misr_compactor_pkg.sv
// Shared types and constants for the response MISR compactor.
package resp_cmp_pkg;

    localparam int RESP_W = 8;
    localparam int SIG_W  = 32;
    localparam int CNT_W  = 16;

    localparam logic [SIG_W-1:0] POLY = 32'h04C1_1DB7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // One MISR step: shift left, fold the MSB back through the polynomial,
    // then XOR the response into the low bits.
    function automatic logic [SIG_W-1:0] misr_next(input logic [SIG_W-1:0]  sig,
                                                   input logic [RESP_W-1:0] data,
                                                   input logic [SIG_W-1:0]  poly);
        misr_next = {sig[SIG_W-2:0], 1'b0}
                  ^ (sig[SIG_W-1] ? poly : '0)
                  ^ {{(SIG_W-RESP_W){1'b0}}, data};
    endfunction

endpackage

// File: rtl/resp_misr_compactor_misr_reg.sv
// Signature register: seed load has priority over an MISR step.
module misr_reg
    import resp_cmp_pkg::*;
#(
    parameter logic [SIG_W-1:0] POLY = resp_cmp_pkg::POLY
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [SIG_W-1:0]  seed,
    input  logic              step,
    input  logic [RESP_W-1:0] data,
    output logic [SIG_W-1:0]  sig
);

    // Signature state: cleared on reset, seeded on load, compacted on step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig <= '0;
        end else if (load) begin
            sig <= seed;
        end else if (step) begin
            sig <= misr_next(sig, data, POLY);
        end
    end

endmodule

// File: rtl/resp_misr_compactor.sv
// Response MISR compactor: counts a programmed number of accepted responses
// into a signature and compares it to a golden value at the end of the run.
// Optional first-mismatch tracking is enabled with RESP_FIRST_FAIL_EN.
//
// Handshake: a response transfers on a rising edge where resp_valid and
// resp_ready are both 1; resp_ready is 1 only in RUN and does not depend on
// resp_valid; the source holds resp_data (and exp_data) stable until transfer.
module resp_misr_compactor
    import resp_cmp_pkg::*;
#(
    parameter logic [SIG_W-1:0] POLY = resp_cmp_pkg::POLY
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [CNT_W-1:0]  cfg_num_pat,
    input  logic [SIG_W-1:0]  cfg_seed,
    input  logic [SIG_W-1:0]  cfg_golden,
    input  logic              resp_valid,
    output logic              resp_ready,
    input  logic [RESP_W-1:0] resp_data,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [SIG_W-1:0]  signature,
    output logic [CNT_W-1:0]  pat_cnt
`ifdef RESP_FIRST_FAIL_EN
   ,input  logic [RESP_W-1:0] exp_data,
    output logic              fail_seen,
    output logic [CNT_W-1:0]  fail_idx
`endif
);

    state_e             state;
    state_e             state_d;
    logic               load;
    logic               accept;
    logic [CNT_W-1:0]   num_q;
    logic [SIG_W-1:0]   golden_q;
    logic [CNT_W-1:0]   cnt_inc;
    logic               fail_flag;

    assign cnt_inc = pat_cnt + 1'b1;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next-state, run load and response accept decode.
    always_comb begin
        state_d = state;
        load    = 1'b0;
        accept  = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = (cfg_num_pat == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (resp_valid) begin
                    accept = 1'b1;
                    if (cnt_inc == num_q) begin
                        state_d = DONE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Pattern counter and per-run configuration latches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pat_cnt  <= '0;
            num_q    <= '0;
            golden_q <= '0;
        end else if (load) begin
            pat_cnt  <= '0;
            num_q    <= cfg_num_pat;
            golden_q <= cfg_golden;
        end else if (accept) begin
            pat_cnt  <= cnt_inc;
        end
    end

    misr_reg #(
        .POLY (POLY)
    ) u_misr (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load),
        .seed  (cfg_seed),
        .step  (accept),
        .data  (resp_data),
        .sig   (signature)
    );

`ifdef RESP_FIRST_FAIL_EN
    // First mismatch in a run is captured; later ones are ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fail_seen <= 1'b0;
            fail_idx  <= '0;
        end else if (load) begin
            fail_seen <= 1'b0;
            fail_idx  <= '0;
        end else if (accept && !fail_seen && (resp_data != exp_data)) begin
            fail_seen <= 1'b1;
            fail_idx  <= pat_cnt;
        end
    end

    assign fail_flag = fail_seen;
`else
    assign fail_flag = 1'b0;
`endif

    assign resp_ready = (state == RUN);
    assign busy       = (state == RUN);
    assign done       = (state == DONE);
    // The signature is frozen in DONE, so a live compare is the final result.
    assign pass       = done && (signature == golden_q) && !fail_flag;

endmodule

// File: tb/tb_resp_misr_compactor.sv
// Directed bench for resp_misr_compactor with a signature scoreboard.
// Build with RESP_FIRST_FAIL_EN to also exercise first-mismatch tracking.
module tb_resp_misr_compactor;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] cfg_num_pat = '0;
    logic [31:0] cfg_seed = '0;
    logic [31:0] cfg_golden = '0;
    logic        resp_valid = 1'b0;
    logic        resp_ready;
    logic [7:0]  resp_data = '0;
    logic        busy;
    logic        done;
    logic        pass;
    logic [31:0] signature;
    logic [15:0] pat_cnt;
`ifdef RESP_FIRST_FAIL_EN
    logic [7:0]  exp_data = '0;
    logic        fail_seen;
    logic [15:0] fail_idx;
`endif

    int          n_tests = 0;
    int          n_fail = 0;
    logic [31:0] exp_q[$];
    logic [31:0] model_sig;
    logic [31:0] gold;
    logic [7:0]  rnd_data[3];

    // Clock: 10 time-unit period.
    always #5 clk = ~clk;

    resp_misr_compactor dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .cfg_num_pat (cfg_num_pat),
        .cfg_seed    (cfg_seed),
        .cfg_golden  (cfg_golden),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_data   (resp_data),
        .busy        (busy),
        .done        (done),
        .pass        (pass),
        .signature   (signature),
        .pat_cnt     (pat_cnt)
`ifdef RESP_FIRST_FAIL_EN
       ,.exp_data    (exp_data),
        .fail_seen   (fail_seen),
        .fail_idx    (fail_idx)
`endif
    );

    // Reference MISR step written bit by bit.
    function automatic logic [31:0] model_next(input logic [31:0] s, input logic [7:0] d);
        logic fb;
        fb = s[31];
        s = s << 1;
        if (fb) s = s ^ 32'h04C1_1DB7;
        s[7:0] = s[7:0] ^ d;
        return s;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // All tasks start and end at posedge + 1.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [15:0] num, input logic [31:0] seed, input logic [31:0] golden);
        cfg_num_pat = num;
        cfg_seed    = seed;
        cfg_golden  = golden;
        start       = 1'b1;
        cycle();
        start       = 1'b0;
    endtask

    // Drive one response, push the model signature, then pop and compare it.
    task automatic send_resp(input logic [7:0] d);
        int waited;
        logic [31:0] e;
        waited = 0;
        while (!resp_ready && waited < 20) begin
            cycle();
            waited++;
        end
        if (!resp_ready) check("ready_timeout", {31'b0, resp_ready}, 32'd1);
        model_sig = model_next(model_sig, d);
        exp_q.push_back(model_sig);
        resp_data  = d;
        resp_valid = 1'b1;
        cycle();
        resp_valid = 1'b0;
        check("sb_size", exp_q.size(), 32'd1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("signature", signature, e);
        end
    endtask

    initial begin
        // Reset state, sampled while reset is asserted.
        #3;
        check("rst_ready", {31'b0, resp_ready}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_pass", {31'b0, pass}, 32'd0);
        check("rst_sig", signature, 32'd0);
        check("rst_cnt", {16'b0, pat_cnt}, 32'd0);
        cycle();
        rst_n = 1'b1;
        cycle();

        // One pattern, zero seed.
        model_sig = 32'h0;
        do_start(16'd1, 32'h0, 32'h0000_00A5);
        check("t1_busy", {31'b0, busy}, 32'd1);
        check("t1_ready", {31'b0, resp_ready}, 32'd1);
        send_resp(8'hA5);
        check("t1_sig_const", signature, 32'h0000_00A5);
        check("t1_done", {31'b0, done}, 32'd1);
        check("t1_pass", {31'b0, pass}, 32'd1);
        check("t1_busy_off", {31'b0, busy}, 32'd0);
        // Valid while in DONE is not accepted.
        resp_data  = 8'h3C;
        resp_valid = 1'b1;
        cycle();
        cycle();
        resp_valid = 1'b0;
        check("done_hold_cnt", {16'b0, pat_cnt}, 32'd1);
        check("done_hold_sig", signature, 32'h0000_00A5);
        check("done_hold_done", {31'b0, done}, 32'd1);

        // Two patterns.
        model_sig = 32'h0;
        do_start(16'd2, 32'h0, 32'h0000_014B);
        check("t2_done_clr", {31'b0, done}, 32'd0);
        send_resp(8'hA5);
        check("t2_mid_done", {31'b0, done}, 32'd0);
        send_resp(8'h01);
        check("t2_sig_const", signature, 32'h0000_014B);
        check("t2_cnt", {16'b0, pat_cnt}, 32'd2);
        check("t2_done", {31'b0, done}, 32'd1);
        check("t2_pass", {31'b0, pass}, 32'd1);

        // Feedback path.
        model_sig = 32'h8000_0000;
        do_start(16'd1, 32'h8000_0000, 32'h0);
        send_resp(8'h00);
        check("t3_sig_const", signature, 32'h04C1_1DB7);
        check("t3_done", {31'b0, done}, 32'd1);
        check("t3_pass", {31'b0, pass}, 32'd0);

        // Zero patterns: straight to DONE.
        do_start(16'd0, 32'h1234_5678, 32'h1234_5678);
        check("t4_ready", {31'b0, resp_ready}, 32'd0);
        check("t4_busy", {31'b0, busy}, 32'd0);
        check("t4_done", {31'b0, done}, 32'd1);
        check("t4_pass", {31'b0, pass}, 32'd1);
        check("t4_sig", signature, 32'h1234_5678);
        check("t4_cnt", {16'b0, pat_cnt}, 32'd0);

        // Start mid-run ignored, then asynchronous reset aborts the run.
        model_sig = 32'hDEAD_BEEF;
        do_start(16'd4, 32'hDEAD_BEEF, 32'h0);
        send_resp(8'h11);
        cycle();
        do_start(16'd1, 32'h0, 32'h0);
        check("t5_busy", {31'b0, busy}, 32'd1);
        check("t5_cnt", {16'b0, pat_cnt}, 32'd1);
        check("t5_sig_kept", signature, model_sig);
        send_resp(8'h22);
        cycle();
        check("t5_cnt2", {16'b0, pat_cnt}, 32'd2);
        #1;
        rst_n = 1'b0;
        #1;
        check("t5_rst_ready", {31'b0, resp_ready}, 32'd0);
        check("t5_rst_busy", {31'b0, busy}, 32'd0);
        check("t5_rst_done", {31'b0, done}, 32'd0);
        check("t5_rst_sig", signature, 32'd0);
        check("t5_rst_cnt", {16'b0, pat_cnt}, 32'd0);
        exp_q.delete();
        cycle();
        rst_n = 1'b1;
        cycle();

        // Fresh random run after reset.
        gold = 32'hCAFE_0001;
        for (int i = 0; i < 3; i++) begin
            rnd_data[i] = 8'($urandom_range(0, 255));
            gold = model_next(gold, rnd_data[i]);
        end
        model_sig = 32'hCAFE_0001;
        do_start(16'd3, 32'hCAFE_0001, gold);
        for (int i = 0; i < 3; i++) begin
            send_resp(rnd_data[i]);
        end
        check("t6_cnt", {16'b0, pat_cnt}, 32'd3);
        check("t6_done", {31'b0, done}, 32'd1);
        check("t6_pass", {31'b0, pass}, 32'd1);

`ifdef RESP_FIRST_FAIL_EN
        // Mismatches at patterns 2 and 4; only the first is recorded.
        gold = 32'h0;
        for (int i = 0; i < 5; i++) gold = model_next(gold, 8'(8'h10 + i));
        model_sig = 32'h0;
        do_start(16'd5, 32'h0, gold);
        check("ff_clr", {31'b0, fail_seen}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            exp_data = 8'(8'h10 + i) ^ ((i == 2 || i == 4) ? 8'h80 : 8'h00);
            send_resp(8'(8'h10 + i));
        end
        check("ff_seen", {31'b0, fail_seen}, 32'd1);
        check("ff_idx", {16'b0, fail_idx}, 32'd2);
        check("ff_sig", signature, gold);
        check("ff_pass", {31'b0, pass}, 32'd0);
        do_start(16'd0, 32'h5, 32'h5);
        check("ff_start_clr", {31'b0, fail_seen}, 32'd0);
        check("ff_pass2", {31'b0, pass}, 32'd1);
`endif

        check("sb_drained", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
